// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle control FSM for the RV32 lw/sw/R/beq subset.
// Sequences a shared-memory datapath, counts retired instructions, traps on bad opcodes.
module multicycle_controller #(
    parameter int         CNT_W  = 32,
    parameter logic [6:0] OP_LW  = 7'b0000011,
    parameter logic [6:0] OP_SW  = 7'b0100011,
    parameter logic [6:0] OP_R   = 7'b0110011,
    parameter logic [6:0] OP_BEQ = 7'b1100011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       imm_src,
    output logic [2:0]       alu_control,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_TRAP     = 4'd9
    } state_t;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [2:0]       funct_op;
    logic             unused_func7;

    // Only func7[5] distinguishes sub from add in this subset.
    assign unused_func7 = ^{func7[6], func7[4:0]};

    assign state   = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

    // State, trap flag and retire counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    // R-type ALU operation selected by func3 (func7[5] picks sub).
    always_comb begin
        funct_op = 3'b000;
        case (func3)
            3'b000:  funct_op = func7[5] ? 3'b001 : 3'b000;
            3'b010:  funct_op = 3'b101;
            3'b110:  funct_op = 3'b011;
            3'b111:  funct_op = 3'b010;
            default: funct_op = 3'b000;
        endcase
    end

    // Next state, datapath controls and retire accounting per state.
    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        instret_d   = instret_q;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        imm_src     = 2'b00;
        alu_control = 3'b000;

        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_R) begin
                    state_d = S_EXECR;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BEQ;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (opcode == OP_SW) begin
                    imm_src = 2'b01;
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
                instret_d  = instret_q + CNT_W'(1);
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    state_d   = S_FETCH;
                    instret_d = instret_q + CNT_W'(1);
                end
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = funct_op;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
                instret_d = instret_q + CNT_W'(1);
            end
            S_BEQ: begin
                alu_src_a   = 2'b10;
                alu_control = 3'b001;
                pc_write    = zero;
                state_d     = S_FETCH;
                instret_d   = instret_q + CNT_W'(1);
            end
            S_TRAP: begin
                illegal_d = 1'b1;
                state_d   = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Nothing reaches the datapath while reset is held.
        if (reset) begin
            mem_req     = 1'b0;
            mem_write   = 1'b0;
            adr_src     = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            reg_write   = 1'b0;
            result_src  = 2'b00;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            imm_src     = 2'b00;
            alu_control = 3'b000;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized bench for the multi-cycle control FSM.
// Expected state traces are built per instruction class and latency.
module tb_multicycle_controller;

    localparam int         CNT_W  = 32;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [6:0]       opcode = '0;
    logic [2:0]       func3 = '0;
    logic [6:0]       func7 = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]       result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]       alu_control;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] instret;
    logic [16:0]      ctl;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] exp_instret = '0;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func3(func3),
        .func7(func7), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .illegal(illegal), .state(state),
        .instret(instret)
    );

    always #5 clk = ~clk;

    assign ctl = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  result_src, alu_src_a, alu_src_b, imm_src, alu_control};

    // R-type operation: sub if func7[5] with func3 000, slt 010, or 110, and 111.
    function automatic logic [2:0] r_op(input logic [2:0] f3, input logic [6:0] f7);
        if (f3 == 3'b000 && f7[5]) return 3'b001;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    // Control word the spec's state table demands for a phase.
    function automatic logic [16:0] exp_ctl(input int st, input logic [6:0] op,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic z, input logic rdy);
        logic mrq, mwr, asr, irw, pcw, rgw;
        logic [1:0] rs, sa, sb, is;
        logic [2:0] ac;
        {mrq, mwr, asr, irw, pcw, rgw} = '0;
        {rs, sa, sb, is, ac} = '0;
        case (st)
            0: begin mrq = 1; sb = 2; rs = 2; irw = rdy; pcw = rdy; end
            1: begin sa = 1; sb = 1; is = 2; end
            2: begin sa = 2; sb = 1; is = (op == OP_SW) ? 2'd1 : 2'd0; end
            3: begin mrq = 1; asr = 1; end
            4: begin rs = 1; rgw = 1; end
            5: begin mrq = 1; mwr = 1; asr = 1; end
            6: begin sa = 2; ac = r_op(f3, f7); end
            7: begin rgw = 1; end
            8: begin sa = 2; ac = 3'b001; pcw = z; end
            default: ;
        endcase
        return {mrq, mwr, asr, irw, pcw, rgw, rs, sa, sb, is, ac};
    endfunction

    // Run one instruction: lf/lm = stall cycles on fetch / data access.
    task automatic run_instr(input string name, input logic [6:0] op,
                             input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input int lf, input int lm);
        int seq[$];
        bit rdy[$];
        bit trap;
        int ms;
        trap = 0;
        for (int i = 0; i < lf; i++) begin seq.push_back(0); rdy.push_back(1'b0); end
        seq.push_back(0); rdy.push_back(1'b1);
        seq.push_back(1); rdy.push_back(1'($urandom_range(0, 1)));
        if (op == OP_LW || op == OP_SW) begin
            ms = (op == OP_LW) ? 3 : 5;
            seq.push_back(2); rdy.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < lm; i++) begin seq.push_back(ms); rdy.push_back(1'b0); end
            seq.push_back(ms); rdy.push_back(1'b1);
            if (op == OP_LW) begin seq.push_back(4); rdy.push_back(1'($urandom_range(0, 1))); end
        end else if (op == OP_R) begin
            seq.push_back(6); rdy.push_back(1'($urandom_range(0, 1)));
            seq.push_back(7); rdy.push_back(1'($urandom_range(0, 1)));
        end else if (op == OP_BEQ) begin
            seq.push_back(8); rdy.push_back(1'($urandom_range(0, 1)));
        end else begin
            trap = 1;
            for (int i = 0; i < 12; i++) begin seq.push_back(9); rdy.push_back(1'($urandom_range(0, 1))); end
        end
        foreach (seq[i]) begin
            if (seq[i] == 0) begin
                opcode = 7'($urandom); func3 = 3'($urandom); func7 = 7'($urandom);
            end else begin
                opcode = op; func3 = f3; func7 = f7;
            end
            mem_ready = rdy[i];
            zero = (seq[i] == 8) ? z : 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (state !== 4'(seq[i])) begin
                n_bad++;
                $display("FAIL %s state cyc%0d: got %0d want %0d", name, i, state, seq[i]);
            end
            n_cmp++;
            if (ctl !== exp_ctl(seq[i], op, f3, f7, z, rdy[i])) begin
                n_bad++;
                $display("FAIL %s ctl cyc%0d st%0d: got %h want %h", name, i, seq[i], ctl,
                         exp_ctl(seq[i], op, f3, f7, z, rdy[i]));
            end
            n_cmp++;
            if (illegal !== (trap && seq[i] == 9)) begin
                n_bad++;
                $display("FAIL %s illegal cyc%0d: got %b want %b", name, i, illegal, trap && seq[i] == 9);
            end
            n_cmp++;
            if (instret !== exp_instret) begin
                n_bad++;
                $display("FAIL %s instret cyc%0d: got %0d want %0d", name, i, instret, exp_instret);
            end
            @(negedge clk);
        end
        if (!trap) exp_instret++;
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (state !== 4'd0 || ctl !== 17'd0 || instret !== '0 || illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got st=%0d ctl=%h ir=%0d ill=%b want 0/0/0/0",
                     name, state, ctl, instret, illegal);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_idle("reset_assert");
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check_idle("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        exp_instret = '0;
    endtask

    task automatic test_lw();
        run_instr("lw_stall", OP_LW, 3'b010, 7'($urandom), 1'b0, 2, 2);
        run_instr("lw_fast", OP_LW, 3'b010, 7'($urandom), 1'b1, 0, 0);
    endtask

    task automatic test_sw();
        run_instr("sw_fast", OP_SW, 3'b010, 7'($urandom), 1'b0, 0, 0);
        run_instr("sw_stall", OP_SW, 3'b010, 7'($urandom), 1'b1, 1, 3);
    endtask

    task automatic test_rtype();
        run_instr("r_sub", OP_R, 3'b000, 7'b0100000, 1'b0, 0, 0);
        run_instr("r_add", OP_R, 3'b000, 7'b0000000, 1'b0, 0, 0);
        run_instr("r_and", OP_R, 3'b111, 7'b0000000, 1'b0, 0, 0);
        run_instr("r_slt", OP_R, 3'b010, 7'b0000000, 1'b0, 0, 0);
        run_instr("r_or", OP_R, 3'b110, 7'b0000000, 1'b0, 1, 0);
        run_instr("r_oth", OP_R, 3'b001, 7'b0100000, 1'b0, 0, 0);
    endtask

    task automatic test_beq();
        run_instr("beq_taken", OP_BEQ, 3'b000, 7'd0, 1'b1, 0, 0);
        run_instr("beq_not", OP_BEQ, 3'b000, 7'd0, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops[4];
        ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R; ops[3] = OP_BEQ;
        for (int k = 0; k < 40; k++) begin
            run_instr("rand", ops[$urandom_range(0, 3)], 3'($urandom), 7'($urandom),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid();
        int st[5] = '{0, 1, 2, 3, 3};
        bit rd[5] = '{1, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            opcode = OP_LW;
            mem_ready = rd[i];
            #1;
            n_cmp++;
            if (state !== 4'(st[i])) begin
                n_bad++;
                $display("FAIL mid_seq cyc%0d: got %0d want %0d", i, state, st[i]);
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_idle("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        exp_instret = '0;
        #1;
        n_cmp++;
        if (state !== 4'd0 || mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_resume: got st=%0d req=%b want 0/1", state, mem_req);
        end
        @(negedge clk);
        run_instr("after_mid", OP_R, 3'b111, 7'd0, 1'b0, 1, 0);
    endtask

    task automatic test_trap();
        run_instr("trap", 7'b0010011, 3'b000, 7'd0, 1'b0, 1, 0);
        test_reset();
        run_instr("post_trap", OP_BEQ, 3'b000, 7'd0, 1'b1, 0, 0);
    endtask

    initial begin
        #2;
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_back_to_back();
        test_reset_mid();
        test_lw();
        test_trap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
